// File: rtl/test_status_monitor.sv
// Pass/fail/timeout monitor for riscv-tests-style programs: snoops each hart's
// regfile writeback, shadows the done/result/id registers and latches a verdict.
module test_status_monitor #(
  parameter int NUM_HARTS      = 1,
  parameter int XLEN           = 32,
  parameter int DONE_REG       = 26,
  parameter int DONE_VAL       = 1,
  parameter int RESULT_REG     = 27,
  parameter int PASS_VAL       = 1,
  parameter int ID_REG         = 3,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 5000,
  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      wb_we_i,
  input  logic [5*NUM_HARTS-1:0]    wb_rd_i,
  input  logic [XLEN*NUM_HARTS-1:0] wb_data_i,
  input  logic [XLEN*NUM_HARTS-1:0] pc_i,
  output logic [NUM_HARTS-1:0]      hart_done_o,
  output logic [NUM_HARTS-1:0]      hart_pass_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [HW-1:0]             fail_hart_o,
  output logic [XLEN-1:0]           fail_id_o,
  output logic [XLEN-1:0]           fail_pc_o,
  output logic [31:0]               cycle_cnt_o
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {H_RUN, H_SETTLE, H_PASS, H_FAIL} hartState_e;
  typedef enum logic [1:0] {G_RUN, G_DONE, G_TIMEOUT} globalState_e;

  hartState_e      hartState_q    [NUM_HARTS];
  hartState_e      hartState_d    [NUM_HARTS];
  logic [SW-1:0]   settleCnt_q    [NUM_HARTS];
  logic [SW-1:0]   settleCnt_d    [NUM_HARTS];
  logic [XLEN-1:0] resultShadow_q [NUM_HARTS];
  logic [XLEN-1:0] resultShadow_d [NUM_HARTS];
  logic [XLEN-1:0] idShadow_q     [NUM_HARTS];
  logic [XLEN-1:0] idShadow_d     [NUM_HARTS];
  logic [XLEN-1:0] trigPc_q       [NUM_HARTS];
  logic [XLEN-1:0] trigPc_d       [NUM_HARTS];

  globalState_e    globalState_q, globalState_d;
  logic [31:0]     cycleCnt_q, cycleCnt_d;
  logic            failValid_q, failValid_d;
  logic [HW-1:0]   failHart_q, failHart_d;
  logic [XLEN-1:0] failId_q, failId_d;
  logic [XLEN-1:0] failPc_q, failPc_d;

  logic [NUM_HARTS-1:0] enterFail;
  logic                 allTermNext;
  logic                 timeoutFire;
  logic                 hartEn;

  // Per-hart shadow tracking and RUN -> SETTLE -> PASS/FAIL sequencing.
  always_comb begin
    logic            hWe;
    logic [4:0]      hRd;
    logic [XLEN-1:0] hData;
    logic [XLEN-1:0] hPc;
    hWe            = 1'b0;
    hRd            = '0;
    hData          = '0;
    hPc            = '0;
    hartState_d    = hartState_q;
    settleCnt_d    = settleCnt_q;
    resultShadow_d = resultShadow_q;
    idShadow_d     = idShadow_q;
    trigPc_d       = trigPc_q;
    enterFail      = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hRd   = wb_rd_i[5*h +: 5];
      hWe   = wb_we_i[h] && (hRd != 5'd0);
      hData = wb_data_i[XLEN*h +: XLEN];
      hPc   = pc_i[XLEN*h +: XLEN];
      if ((hartState_q[h] == H_RUN) || (hartState_q[h] == H_SETTLE)) begin
        if (hWe && hRd == 5'(RESULT_REG)) resultShadow_d[h] = hData;
        if (hWe && hRd == 5'(ID_REG))     idShadow_d[h]     = hData;
      end
      unique case (hartState_q[h])
        H_RUN: begin
          if (hWe && hRd == 5'(DONE_REG) && hData == XLEN'(DONE_VAL)) begin
            hartState_d[h] = H_SETTLE;
            trigPc_d[h]    = hPc;
            settleCnt_d[h] = SW'(SETTLE_CYCLES);
          end
        end
        H_SETTLE: begin
          // Verdict uses the result shadow as it stood before this edge.
          if (settleCnt_q[h] == '0) begin
            if (resultShadow_q[h] == XLEN'(PASS_VAL)) begin
              hartState_d[h] = H_PASS;
            end else begin
              hartState_d[h] = H_FAIL;
              enterFail[h]   = 1'b1;
            end
          end else begin
            settleCnt_d[h] = settleCnt_q[h] - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Global verdict; completion at the timeout edge takes priority over timeout.
  always_comb begin
    allTermNext = 1'b1;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (!((hartState_d[h] == H_PASS) || (hartState_d[h] == H_FAIL))) allTermNext = 1'b0;
    end
    timeoutFire   = (TIMEOUT_CYCLES != 0) && (cycleCnt_q == 32'(TIMEOUT_CYCLES - 1)) && !allTermNext;
    hartEn        = (globalState_q == G_RUN) && !timeoutFire;
    globalState_d = globalState_q;
    cycleCnt_d    = cycleCnt_q;
    if (globalState_q == G_RUN) begin
      if (allTermNext)      globalState_d = G_DONE;
      else if (timeoutFire) globalState_d = G_TIMEOUT;
      if (cycleCnt_q != '1) cycleCnt_d = cycleCnt_q + 32'd1;
    end
  end

  always_comb begin
    failValid_d = failValid_q;
    failHart_d  = failHart_q;
    failId_d    = failId_q;
    failPc_d    = failPc_q;
    // Descending scan so the lowest failing index is the one that sticks.
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (enterFail[h] && (!failValid_q || (HW'(h) < failHart_q))) begin
        failValid_d = 1'b1;
        failHart_d  = HW'(h);
        failId_d    = idShadow_q[h];
        failPc_d    = trigPc_q[h];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hartState_q    <= '{default: H_RUN};
      settleCnt_q    <= '{default: '0};
      resultShadow_q <= '{default: '0};
      idShadow_q     <= '{default: '0};
      trigPc_q       <= '{default: '0};
      globalState_q  <= G_RUN;
      cycleCnt_q     <= '0;
      failValid_q    <= 1'b0;
      failHart_q     <= '0;
      failId_q       <= '0;
      failPc_q       <= '0;
    end else begin
      globalState_q <= globalState_d;
      cycleCnt_q    <= cycleCnt_d;
      if (hartEn) begin
        hartState_q    <= hartState_d;
        settleCnt_q    <= settleCnt_d;
        resultShadow_q <= resultShadow_d;
        idShadow_q     <= idShadow_d;
        trigPc_q       <= trigPc_d;
        failValid_q    <= failValid_d;
        failHart_q     <= failHart_d;
        failId_q       <= failId_d;
        failPc_q       <= failPc_d;
      end
    end
  end

  always_comb begin
    hart_done_o = '0;
    hart_pass_o = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hart_done_o[h] = (hartState_q[h] == H_PASS) || (hartState_q[h] == H_FAIL);
      hart_pass_o[h] = (hartState_q[h] == H_PASS);
    end
  end

  assign done_o      = (globalState_q != G_RUN);
  assign timeout_o   = (globalState_q == G_TIMEOUT);
  assign pass_o      = (globalState_q == G_DONE) && (&hart_pass_o);
  assign fail_hart_o = failHart_q;
  assign fail_id_o   = failId_q;
  assign fail_pc_o   = failPc_q;
  assign cycle_cnt_o = cycleCnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench: a single-hart monitor with a 20-cycle budget and a four-hart
// monitor without a budget, sharing clock and reset.
module tb_test_status_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]  aWe;
  logic [4:0]  aRd;
  logic [31:0] aData, aPc;
  logic [0:0]  aHartDone, aHartPass, aFailHart;
  logic        aDone, aPass, aTimeout;
  logic [31:0] aFailId, aFailPc, aCycleCnt;

  logic [3:0]   bWe;
  logic [19:0]  bRd;
  logic [127:0] bData, bPc;
  logic [3:0]   bHartDone, bHartPass;
  logic [1:0]   bFailHart;
  logic         bDone, bPass, bTimeout;
  logic [31:0]  bFailId, bFailPc, bCycleCnt;

  int numVectors = 0;
  int numMiscompares = 0;

  test_status_monitor #(.NUM_HARTS(1), .TIMEOUT_CYCLES(20)) dutA (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(aWe), .wb_rd_i(aRd), .wb_data_i(aData), .pc_i(aPc),
    .hart_done_o(aHartDone), .hart_pass_o(aHartPass),
    .done_o(aDone), .pass_o(aPass), .timeout_o(aTimeout),
    .fail_hart_o(aFailHart), .fail_id_o(aFailId), .fail_pc_o(aFailPc),
    .cycle_cnt_o(aCycleCnt)
  );

  test_status_monitor #(.NUM_HARTS(4), .TIMEOUT_CYCLES(0)) dutB (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(bWe), .wb_rd_i(bRd), .wb_data_i(bData), .pc_i(bPc),
    .hart_done_o(bHartDone), .hart_pass_o(bHartPass),
    .done_o(bDone), .pass_o(bPass), .timeout_o(bTimeout),
    .fail_hart_o(bFailHart), .fail_id_o(bFailId), .fail_pc_o(bFailPc),
    .cycle_cnt_o(bCycleCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numVectors++;
    assert (observed === expected) else begin
      numMiscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setHart(input int h, input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
    bWe[h]          = 1'b1;
    bRd[5*h +: 5]   = rd;
    bData[32*h +: 32] = data;
    bPc[32*h +: 32]   = pc;
  endtask

  // Drives one dut A write (plus any staged dut B writes) across one rising edge.
  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
    aWe   = we;
    aRd   = rd;
    aData = data;
    aPc   = pc;
    @(posedge clk);
    #1;
    aWe = '0;
    bWe = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    aWe = '0; aRd = '0; aData = '0; aPc = '0;
    bWe = '0; bRd = '0; bData = '0; bPc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    resetDut();
    checkOutput("reset_done", {31'd0, aDone}, 32'd0);
    checkOutput("reset_cnt", aCycleCnt, 32'd0);
    checkOutput("reset_hart_done", {28'd0, bHartDone}, 32'd0);

    // Pass with trigger at cycle 10.
    idle(4);
    applyStimulus(1'b1, 5'd27, 32'd1, 32'h8000_0010);
    idle(4);
    checkOutput("cnt_at_9", aCycleCnt, 32'd9);
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h8000_0040);
    idle(5);
    checkOutput("pass_hart_done_e15", {31'd0, aHartDone}, 32'd0);
    checkOutput("pass_done_e15", {31'd0, aDone}, 32'd0);
    idle(1);
    checkOutput("pass_hart_done_e16", {31'd0, aHartDone}, 32'd1);
    checkOutput("pass_hart_pass_e16", {31'd0, aHartPass}, 32'd1);
    checkOutput("pass_done_e16", {31'd0, aDone}, 32'd1);
    checkOutput("pass_pass_e16", {31'd0, aPass}, 32'd1);
    checkOutput("pass_timeout_e16", {31'd0, aTimeout}, 32'd0);
    checkOutput("pass_cnt_e16", aCycleCnt, 32'd16);
    idle(6);
    checkOutput("pass_no_late_timeout", {31'd0, aTimeout}, 32'd0);
    checkOutput("pass_held", {31'd0, aPass}, 32'd1);

    // Fail with captured id and pc.
    resetDut();
    applyStimulus(1'b1, 5'd3, 32'd7, 32'h8000_0030);
    applyStimulus(1'b1, 5'd27, 32'd0, 32'h8000_0038);
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h8000_0044);
    idle(6);
    checkOutput("fail_done", {31'd0, aDone}, 32'd1);
    checkOutput("fail_pass", {31'd0, aPass}, 32'd0);
    checkOutput("fail_hart_pass", {31'd0, aHartPass}, 32'd0);
    checkOutput("fail_id", aFailId, 32'd7);
    checkOutput("fail_pc", aFailPc, 32'h8000_0044);
    checkOutput("fail_hart", {31'd0, aFailHart}, 32'd0);

    // Result written 3 cycles after the trigger is seen.
    resetDut();
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h100);
    idle(2);
    applyStimulus(1'b1, 5'd27, 32'd1, 32'h10c);
    idle(2);
    checkOutput("late_res_not_done_e6", {31'd0, aHartDone}, 32'd0);
    idle(1);
    checkOutput("late_res_pass", {31'd0, aPass}, 32'd1);

    // Result written at the verdict edge is not seen.
    resetDut();
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h100);
    idle(5);
    applyStimulus(1'b1, 5'd27, 32'd1, 32'h118);
    checkOutput("verdict_edge_done", {31'd0, aDone}, 32'd1);
    checkOutput("verdict_edge_pass", {31'd0, aPass}, 32'd0);
    checkOutput("verdict_edge_hart_pass", {31'd0, aHartPass}, 32'd0);

    // Timeout with a discarded trigger at cycle 19.
    resetDut();
    idle(19);
    checkOutput("to_cnt_19", aCycleCnt, 32'd19);
    checkOutput("to_not_yet", {31'd0, aTimeout}, 32'd0);
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h200);
    checkOutput("to_timeout", {31'd0, aTimeout}, 32'd1);
    checkOutput("to_done", {31'd0, aDone}, 32'd1);
    checkOutput("to_pass", {31'd0, aPass}, 32'd0);
    idle(8);
    checkOutput("to_trigger_discarded", {31'd0, aHartDone}, 32'd0);

    // Four harts: 1 and 3 fail together, 2 passes, 0 passes late; dut A mid-settle at reset.
    resetDut();
    idle(1);
    setHart(1, 5'd3, 32'd5, 32'h0f0);
    setHart(3, 5'd3, 32'd9, 32'h2f0);
    setHart(2, 5'd27, 32'd1, 32'h1f0);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0);
    setHart(1, 5'd26, 32'd1, 32'h100);
    setHart(3, 5'd26, 32'd1, 32'h300);
    setHart(2, 5'd26, 32'd1, 32'h200);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0);
    idle(1);
    setHart(0, 5'd27, 32'd1, 32'h010);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0);
    idle(3);
    checkOutput("mh_hart_done_e8", {28'd0, bHartDone}, 32'd0);
    idle(1);
    checkOutput("mh_hart_done_e9", {28'd0, bHartDone}, 32'he);
    checkOutput("mh_hart_pass_e9", {28'd0, bHartPass}, 32'h4);
    checkOutput("mh_done_e9", {31'd0, bDone}, 32'd0);
    checkOutput("mh_fail_hart", {30'd0, bFailHart}, 32'd1);
    checkOutput("mh_fail_id", bFailId, 32'd5);
    checkOutput("mh_fail_pc", bFailPc, 32'h100);
    idle(2);
    setHart(0, 5'd26, 32'd1, 32'h020);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0);
    idle(2);
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h400);
    idle(2);
    checkOutput("mh_done_e17", {31'd0, bDone}, 32'd0);
    idle(1);
    checkOutput("mh_done_e18", {31'd0, bDone}, 32'd1);
    checkOutput("mh_pass_e18", {31'd0, bPass}, 32'd0);
    checkOutput("mh_hart_pass_e18", {28'd0, bHartPass}, 32'h5);
    checkOutput("mh_fail_hart_held", {30'd0, bFailHart}, 32'd1);
    checkOutput("mh_timeout", {31'd0, bTimeout}, 32'd0);
    idle(1);
    checkOutput("settle_a_not_done", {31'd0, aHartDone}, 32'd0);
    checkOutput("settle_a_cnt", aCycleCnt, 32'd19);

    rst_n = 1'b0;
    #2;
    checkOutput("async_a_cnt", aCycleCnt, 32'd0);
    checkOutput("async_b_done", {31'd0, bDone}, 32'd0);
    checkOutput("async_b_hart_done", {28'd0, bHartDone}, 32'd0);
    checkOutput("async_b_fail_id", bFailId, 32'd0);
    checkOutput("async_b_fail_pc", bFailPc, 32'd0);
    checkOutput("async_b_fail_hart", {30'd0, bFailHart}, 32'd0);

    // After reset: x0 write and a non-trigger done value, then a real trigger.
    resetDut();
    applyStimulus(1'b1, 5'd27, 32'd1, 32'h500);
    applyStimulus(1'b1, 5'd0, 32'd1, 32'h504);
    applyStimulus(1'b1, 5'd26, 32'd2, 32'h508);
    idle(6);
    checkOutput("nontrig_not_done", {31'd0, aHartDone}, 32'd0);
    applyStimulus(1'b1, 5'd26, 32'd1, 32'h50c);
    idle(5);
    checkOutput("retrig_not_done_e15", {31'd0, aDone}, 32'd0);
    idle(1);
    checkOutput("retrig_pass", {31'd0, aPass}, 32'd1);
    checkOutput("retrig_fail_pc_clear", aFailPc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
